// File: rtl/lc_pkg.sv
// Shared constants and types for the bank-switched language card.
package lc_pkg;
  localparam logic [7:0] SW_BASE = 8'hC0;
  localparam logic [1:0] REG_TOP = 2'b11;
  localparam logic [3:0] REG_D   = 4'hD;
  localparam int         BANK_W  = 3;
  localparam int         OFF_W   = 14;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } wen_state_t;
endpackage

// File: rtl/lc_bank_card_if.sv
// CPU-side access bus and card response signals.
interface lc_bank_card_if
  import lc_pkg::*;
#(
  parameter int AW = 18
);
  logic              strobe;
  logic [15:0]       addr;
  logic              we;
  logic [AW-1:0]     ram_addr;
  logic              card_ram_rd;
  logic              card_ram_we;
  logic              bank1;
  logic              bsr_readram;
  logic [BANK_W-1:0] bank_sel;

  modport master (
    output strobe, addr, we,
    input  ram_addr, card_ram_rd, card_ram_we, bank1, bsr_readram, bank_sel
  );

  modport slave (
    input  strobe, addr, we,
    output ram_addr, card_ram_rd, card_ram_we, bank1, bsr_readram, bank_sel
  );
endinterface

// File: rtl/lc_switch_fsm.sv
// Mode soft-switch decode: Dxxx bank select, read enable and the double-read write-enable state machine.
module lc_switch_fsm
  import lc_pkg::*;
#(
  parameter bit LC_ONLY = 1'b0
) (
  input  logic       mclk28,
  input  logic       reset_in_n,
  input  logic       i_ev,
  input  logic [3:0] i_addr,
  input  logic       i_we,
  output logic       o_bank1,
  output logic       o_read_en,
  output logic       o_write_en
);

  wen_state_t r_state;

  // addr[2] selects the bank register on slotted cards; plain LC has only mode switches
  always_ff @(posedge mclk28 or negedge reset_in_n) begin
    if (!reset_in_n) begin
      r_state    <= ST_IDLE;
      o_bank1    <= 1'b0;
      o_read_en  <= 1'b0;
      o_write_en <= 1'b1;
    end else if (i_ev && (LC_ONLY || !i_addr[2])) begin
      o_bank1   <= i_addr[3];
      o_read_en <= ~(i_addr[0] ^ i_addr[1]);
      if (!i_addr[0]) begin
        o_write_en <= 1'b0;
        r_state    <= ST_IDLE;
      end else if (i_we) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE:  r_state    <= ST_ARMED;
          ST_ARMED: o_write_en <= 1'b1;
          default:  r_state    <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/lc_bank_card.sv
// Bank-switched RAM card: soft-switch decode, bank register and $D000-$FFFF to RAM mapping.
module lc_bank_card
  import lc_pkg::*;
#(
  parameter int SLOT  = 1,
  parameter int BANKS = 8,
  parameter int BASE  = 'h10000,
  parameter int AW    = 18
) (
  input logic           mclk28,
  input logic           reset_in_n,
  lc_bank_card_if.slave bus
);

  localparam logic [2:0]        SLOT_L    = 3'(SLOT);
  localparam bit                LC_ONLY   = (SLOT == 0);
  localparam logic [BANK_W-1:0] BANK_MASK = BANK_W'(BANKS - 1);
  localparam logic [AW-1:0]     BASE_A    = AW'(BASE);

  logic              r_strobe_d;
  logic              r_live;
  logic              w_ev;
  logic              w_hit;
  logic              w_bank1;
  logic              w_read_en;
  logic              w_write_en;
  logic              w_def;
  logic              w_dxxx;
  logic              w_rd;
  logic              w_wr;
  logic [BANK_W-1:0] w_bank_sel;
  logic [OFF_W-1:0]  w_off;
  logic [AW-1:0]     w_map;

  // r_live stays low until strobe is seen low, so a strobe held across reset release is not an event
  always_ff @(posedge mclk28 or negedge reset_in_n) begin
    if (!reset_in_n) begin
      r_strobe_d <= 1'b0;
      r_live     <= 1'b0;
    end else begin
      r_strobe_d <= bus.strobe;
      if (!bus.strobe) r_live <= 1'b1;
    end
  end

  assign w_ev  = bus.strobe & ~r_strobe_d & r_live;
  assign w_hit = w_ev & (bus.addr[15:4] == {SW_BASE, 1'b1, SLOT_L});

  generate
    if (LC_ONLY) begin : g_lc
      assign w_bank_sel = '0;
    end else begin : g_bank
      logic [BANK_W-1:0] r_bank_sel;
      always_ff @(posedge mclk28 or negedge reset_in_n) begin
        if (!reset_in_n) r_bank_sel <= '0;
        else if (w_hit && bus.addr[2])
          r_bank_sel <= {bus.addr[3], bus.addr[1], bus.addr[0]} & BANK_MASK;
      end
      assign w_bank_sel = r_bank_sel;
    end
  endgenerate

  lc_switch_fsm #(
    .LC_ONLY (LC_ONLY)
  ) u_fsm (
    .mclk28     (mclk28),
    .reset_in_n (reset_in_n),
    .i_ev       (w_hit),
    .i_addr     (bus.addr[3:0]),
    .i_we       (bus.we),
    .o_bank1    (w_bank1),
    .o_read_en  (w_read_en),
    .o_write_en (w_write_en)
  );

  assign w_def  = (bus.addr[15:14] == REG_TOP) && (bus.addr[13:12] != 2'b00);
  assign w_dxxx = (bus.addr[15:12] == REG_D);
  // Dxxx bank 1 folds onto the unused $C000 hole of the 16K window
  assign w_off  = {bus.addr[13], bus.addr[12] & ~(w_bank1 & w_dxxx), bus.addr[11:0]};
  assign w_rd   = w_def & ~bus.we & w_read_en;
  assign w_wr   = w_def & bus.we & w_write_en;

  always_comb begin
    w_map = BASE_A + AW'({w_bank_sel, {OFF_W{1'b0}}}) + AW'(w_off);
    if (LC_ONLY) w_map = AW'({bus.addr[15:14], w_off});
  end

  assign bus.ram_addr    = (w_rd | w_wr) ? w_map : AW'(bus.addr);
  assign bus.card_ram_rd = w_rd;
  assign bus.card_ram_we = w_wr;
  assign bus.bank1       = w_bank1;
  assign bus.bsr_readram = w_read_en;
  assign bus.bank_sel    = w_bank_sel;

endmodule

// File: tb/tb_lc_bank_card.sv
// Directed bench for three card configurations (slot 1 x8 banks, slot 1 x4 banks, plain LC) sharing one CPU bus.
module tb_lc_bank_card;
  typedef struct {
    logic        rd;
    logic        wr;
    logic        b1;
    logic        bsr;
    logic [2:0]  bs;
    logic [17:0] ra;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        strobe;
  logic [15:0] addr;
  logic        we;

  int n_pass  = 0;
  int n_total = 0;

  exp_t sb[$];
  exp_t last[3];

  int         m_slot [3] = '{1, 1, 0};
  int         m_banks[3] = '{8, 4, 8};
  logic       m_b1 [3];
  logic       m_re [3];
  logic       m_we [3];
  logic       m_pre[3];
  logic [2:0] m_bank[3];

  lc_bank_card_if #(.AW(18)) if0 ();
  lc_bank_card_if #(.AW(18)) if1 ();
  lc_bank_card_if #(.AW(18)) if2 ();

  assign if0.strobe = strobe;
  assign if0.addr   = addr;
  assign if0.we     = we;
  assign if1.strobe = strobe;
  assign if1.addr   = addr;
  assign if1.we     = we;
  assign if2.strobe = strobe;
  assign if2.addr   = addr;
  assign if2.we     = we;

  lc_bank_card #(.SLOT(1), .BANKS(8), .BASE('h10000), .AW(18)) dut0 (
    .mclk28(clk), .reset_in_n(rst_n), .bus(if0));
  lc_bank_card #(.SLOT(1), .BANKS(4), .BASE('h10000), .AW(18)) dut1 (
    .mclk28(clk), .reset_in_n(rst_n), .bus(if1));
  lc_bank_card #(.SLOT(0), .BANKS(8), .BASE('h10000), .AW(18)) dut2 (
    .mclk28(clk), .reset_in_n(rst_n), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_b1[d] = 1'b0; m_re[d] = 1'b0; m_we[d] = 1'b1; m_pre[d] = 1'b0; m_bank[d] = 3'd0;
    end
  endtask

  function automatic exp_t model_out(int d, logic [15:0] a, logic w);
    exp_t e;
    logic def, dx;
    logic [13:0] off;
    def  = (a[15:14] == 2'b11) && (a[13:12] != 2'b00);
    dx   = (a[15:12] == 4'hD);
    off  = {a[13], a[12] & ~(m_b1[d] & dx), a[11:0]};
    e.rd = def & ~w & m_re[d];
    e.wr = def & w & m_we[d];
    e.b1 = m_b1[d];
    e.bsr = m_re[d];
    e.bs = m_bank[d];
    if (e.rd | e.wr)
      e.ra = (m_slot[d] == 0) ? {2'b00, a[15:14], off}
                              : 18'(32'h10000 + 32'(m_bank[d]) * 16384 + 32'(off));
    else
      e.ra = {2'b00, a};
    return e;
  endfunction

  task automatic model_update(input logic [15:0] a, input logic w);
    for (int d = 0; d < 3; d++) begin
      logic [2:0] s3;
      s3 = 3'(m_slot[d]);
      if (a[15:4] == {8'hC0, 1'b1, s3}) begin
        if (m_slot[d] == 0 || !a[2]) begin
          m_b1[d] = a[3];
          m_re[d] = ~(a[0] ^ a[1]);
          if (!a[0]) begin
            m_we[d] = 1'b0; m_pre[d] = 1'b0;
          end else if (w) m_pre[d] = 1'b0;
          else if (!m_pre[d]) m_pre[d] = 1'b1;
          else m_we[d] = 1'b1;
        end else begin
          m_bank[d] = 3'(32'({a[3], a[1], a[0]}) % m_banks[d]);
        end
      end
    end
  endtask

  task automatic push_exp(input logic [15:0] a, input logic w);
    for (int d = 0; d < 3; d++) sb.push_back(model_out(d, a, w));
  endtask

  task automatic check_all(input string tag);
    for (int d = 0; d < 3; d++) begin
      exp_t e, g;
      e = sb.pop_front();
      case (d)
        0: g = '{if0.card_ram_rd, if0.card_ram_we, if0.bank1, if0.bsr_readram, if0.bank_sel, if0.ram_addr};
        1: g = '{if1.card_ram_rd, if1.card_ram_we, if1.bank1, if1.bsr_readram, if1.bank_sel, if1.ram_addr};
        default: g = '{if2.card_ram_rd, if2.card_ram_we, if2.bank1, if2.bsr_readram, if2.bank_sel, if2.ram_addr};
      endcase
      last[d] = g;
      chk($sformatf("%s d%0d rd", tag, d),   32'(g.rd),  32'(e.rd));
      chk($sformatf("%s d%0d we", tag, d),   32'(g.wr),  32'(e.wr));
      chk($sformatf("%s d%0d bank1", tag, d), 32'(g.b1), 32'(e.b1));
      chk($sformatf("%s d%0d bsr", tag, d),  32'(g.bsr), 32'(e.bsr));
      chk($sformatf("%s d%0d bsel", tag, d), 32'(g.bs),  32'(e.bs));
      chk($sformatf("%s d%0d raddr", tag, d), 32'(g.ra), 32'(e.ra));
    end
  endtask

  task automatic access(input string tag, input logic [15:0] a, input logic w);
    @(negedge clk);
    addr = a; we = w; strobe = 1'b1;
    push_exp(a, w);
    #2 check_all(tag);
    model_update(a, w);
    @(negedge clk);
    strobe = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; strobe = 1'b0; addr = 16'h0000; we = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #2 push_exp(addr, we);
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    access("rd_d000_reset", 16'hD000, 1'b0);
    chk("tp_rd_d000_off", 32'(last[0].rd), 32'h0);
    access("wr_d000_reset", 16'hD000, 1'b1);
    chk("tp_wr_d000_we", 32'(last[0].wr), 32'h1);
    chk("tp_wr_d000_addr", 32'(last[0].ra), 32'h11000);

    access("c093_a", 16'hC093, 1'b0);
    access("c093_b", 16'hC093, 1'b0);
    access("rd_e000", 16'hE000, 1'b0);
    chk("tp_rd_e000_rd", 32'(last[0].rd), 32'h1);
    chk("tp_rd_e000_addr", 32'(last[0].ra), 32'h12000);
    access("wr_e000", 16'hE000, 1'b1);
    chk("tp_wr_e000_we", 32'(last[0].wr), 32'h1);

    access("c090_clr", 16'hC090, 1'b0);
    access("c093_r1", 16'hC093, 1'b0);
    access("c093_w", 16'hC093, 1'b1);
    access("c093_r2", 16'hC093, 1'b0);
    access("wr_d000_pre", 16'hD000, 1'b1);
    chk("tp_pre_cleared_we", 32'(last[0].wr), 32'h0);
    access("c093_r3", 16'hC093, 1'b0);
    access("wr_d000_armed", 16'hD000, 1'b1);
    chk("tp_double_read_we", 32'(last[0].wr), 32'h1);
    access("c090_off", 16'hC090, 1'b0);
    access("wr_d000_off", 16'hD000, 1'b1);
    chk("tp_c090_we", 32'(last[0].wr), 32'h0);

    access("c09f_bank", 16'hC09F, 1'b0);
    access("c09b_mode", 16'hC09B, 1'b0);
    access("rd_d123", 16'hD123, 1'b0);
    chk("tp_b8_bank", 32'(last[0].bs), 32'h7);
    chk("tp_b8_addr", 32'(last[0].ra), 32'h2C123);
    chk("tp_b4_bank", 32'(last[1].bs), 32'h3);
    chk("tp_b4_addr", 32'(last[1].ra), 32'h1C123);

    access("c08b_a", 16'hC08B, 1'b0);
    access("c08b_b", 16'hC08B, 1'b0);
    access("rd_d456", 16'hD456, 1'b0);
    chk("tp_lc_rd", 32'(last[2].rd), 32'h1);
    chk("tp_lc_addr", 32'(last[2].ra), 32'h0C456);

    access("c090_hold_pre", 16'hC090, 1'b0);
    @(negedge clk);
    addr = 16'hC093; we = 1'b0; strobe = 1'b1;
    push_exp(addr, we);
    #2 check_all("hold_c093");
    model_update(addr, we);
    repeat (10) @(negedge clk);
    strobe = 1'b0;
    access("wr_e000_hold", 16'hE000, 1'b1);
    chk("tp_hold_one_event", 32'(last[0].wr), 32'h0);
    access("c093_after_hold", 16'hC093, 1'b0);
    access("wr_e000_armed", 16'hE000, 1'b1);
    chk("tp_hold_then_read_we", 32'(last[0].wr), 32'h1);

    @(negedge clk);
    addr = 16'hE000; we = 1'b0; strobe = 1'b1;
    push_exp(addr, we);
    #2 check_all("rd_e000_pre_rst");
    model_update(addr, we);
    @(negedge clk);
    rst_n = 1'b0;
    #1 model_reset();
    push_exp(addr, we);
    check_all("mid_reset");
    chk("tp_mid_reset_rd", 32'(last[0].rd), 32'h0);
    @(negedge clk);
    addr = 16'hC09B;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #2 push_exp(addr, we);
    check_all("held_over_release");
    chk("tp_no_event_release", 32'(last[0].bsr), 32'h0);
    @(negedge clk);
    strobe = 1'b0;
    access("c09b_after_rst", 16'hC09B, 1'b0);
    access("rd_d000_after_rst", 16'hD000, 1'b0);
    chk("tp_post_reset_rd", 32'(last[0].rd), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
